// File: rtl/bounce_pkg.sv
// Shared definitions for the bounce generator: FSM states, LFSR geometry
// and the default seed used when a zero seed is requested.
package bounce_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    BOUNCE = 1'b1
  } state_t;

  localparam int                LFSR_W       = 8;
  localparam logic [LFSR_W-1:0] LFSR_TAPS    = 8'hB8;
  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 8'hA5;
  localparam int                CNT_W        = 5;

endpackage

// File: rtl/bounce_gen_lfsr8.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4) that advances every cycle.
// A non-zero seed keeps it away from the all-zero lock-up state.
module lfsr8
  import bounce_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] q
);

  logic [LFSR_W-1:0] r_q;
  logic              w_fb;

  assign w_fb = ^(r_q & LFSR_TAPS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_q <= seed;
    else     r_q <= {r_q[LFSR_W-2:0], w_fb};
  end

  assign q = r_q;

endmodule

// File: rtl/bounce_gen.sv
// Contact-bounce stimulus generator: reproduces in_clean with a burst of
// toggles before settling. Define BOUNCE_FIXED_GAP_EN for fixed MIN_GAP gaps.
module bounce_gen
  import bounce_pkg::*;
#(
  parameter int          BOUNCE_CNT = 3,
  parameter int          MIN_GAP    = 2,
  parameter int          GAP_W      = 2,
  parameter logic [7:0]  SEED       = 8'hA5
) (
  input  logic clk,
  input  logic rst,
  input  logic in_clean,
  output logic out,
  output logic busy,
  output logic done,
  output logic level
);

  localparam logic [CNT_W-1:0] TOGGLES = CNT_W'(2 * BOUNCE_CNT);

  state_t           r_state, w_stateNext;
  logic [CNT_W-1:0] r_gapCnt, w_gapNext;
  logic [CNT_W-1:0] r_togCnt, w_togNext;
  logic             r_out, w_outNext;
  logic             r_level, w_levelNext;
  logic             r_busy, w_busyNext;
  logic             r_done, w_doneNext;
  logic [CNT_W-1:0] w_gap;
  logic [CNT_W-1:0] w_gapLoad;
  logic             w_gapZero;
  logic             w_final;
  logic             w_start;

`ifdef BOUNCE_FIXED_GAP_EN
  assign w_gap = CNT_W'(MIN_GAP);
`else
  localparam logic [LFSR_W-1:0] SEED_EFF = (SEED == 8'h00) ? DEFAULT_SEED : SEED;

  logic [LFSR_W-1:0] w_lfsr;

  lfsr8 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .seed (SEED_EFF),
    .q    (w_lfsr)
  );

  // Only the low GAP_W bits of the LFSR contribute to the gap.
  assign w_gap = CNT_W'(MIN_GAP + (int'(w_lfsr) % (1 << GAP_W)));
`endif

  assign w_gapLoad = w_gap - CNT_W'(1);
  assign w_gapZero = (r_gapCnt == '0);
  assign w_final   = (r_state == BOUNCE) && w_gapZero && (r_togCnt == CNT_W'(1));
  // The final toggle wins over a new level; the restart happens next edge.
  assign w_start   = !w_final && (in_clean != r_level);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_gapCnt <= '0;
      r_togCnt <= '0;
      r_out    <= 1'b0;
      r_level  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_stateNext;
      r_gapCnt <= w_gapNext;
      r_togCnt <= w_togNext;
      r_out    <= w_outNext;
      r_level  <= w_levelNext;
      r_busy   <= w_busyNext;
      r_done   <= w_doneNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_gapNext   = r_gapCnt;
    w_togNext   = r_togCnt;
    w_outNext   = r_out;
    w_levelNext = r_level;
    w_busyNext  = r_busy;
    w_doneNext  = 1'b0;
    if (w_start) begin
      w_stateNext = BOUNCE;
      w_levelNext = in_clean;
      w_outNext   = in_clean;
      w_busyNext  = 1'b1;
      w_togNext   = TOGGLES;
      w_gapNext   = w_gapLoad;
    end else begin
      case (r_state)
        BOUNCE: begin
          if (w_final) begin
            w_outNext   = ~r_out;
            w_togNext   = '0;
            w_gapNext   = '0;
            w_doneNext  = 1'b1;
            w_busyNext  = 1'b0;
            w_stateNext = IDLE;
          end else if (w_gapZero) begin
            w_outNext = ~r_out;
            w_togNext = r_togCnt - CNT_W'(1);
            w_gapNext = w_gapLoad;
          end else begin
            w_gapNext = r_gapCnt - CNT_W'(1);
          end
        end
        default: w_stateNext = IDLE;
      endcase
    end
  end

  assign out   = r_out;
  assign busy  = r_busy;
  assign done  = r_done;
  assign level = r_level;

endmodule

// File: tb/tb_bounce_gen.sv
// Self-checking bench for bounce_gen: directed and random in_clean activity
// compared each cycle against a toggle-schedule reference model.
module tb_bounce_gen;

  localparam int         BOUNCE_CNT = 3;
  localparam int         MIN_GAP    = 2;
  localparam int         GAP_W      = 2;
  localparam logic [7:0] SEED       = 8'hA5;

  logic clk = 1'b0;
  logic rst;
  logic in_clean;
  logic out;
  logic busy;
  logic done;
  logic level;

  int checks   = 0;
  int failures = 0;
  int edgeNum  = 0;

  logic [7:0] mLfsr;
  logic       mOut, mLevel, mBusy, mDone, mActive;
  int         mNextToggle, mTogglesLeft;

  logic cur;
  int   hold;
  logic found;

  always #5 clk = ~clk;

  bounce_gen #(
    .BOUNCE_CNT (BOUNCE_CNT),
    .MIN_GAP    (MIN_GAP),
    .GAP_W      (GAP_W),
    .SEED       (SEED)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_clean (in_clean),
    .out      (out),
    .busy     (busy),
    .done     (done),
    .level    (level)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed %0h expected %0h (edge %0d)", tag, observed, expected, edgeNum);
    end
  endtask

  // Taps 8,6,5,4 counted from 1 at the LSB end, shifting toward the MSB.
  function automatic logic [7:0] lfsrNext(input logic [7:0] x);
    logic fb;
    fb = x[7] ^ x[5] ^ x[4] ^ x[3];
    return {x[6:0], fb};
  endfunction

  function automatic int gapOf(input logic [7:0] lfsrVal);
`ifdef BOUNCE_FIXED_GAP_EN
    return MIN_GAP;
`else
    return MIN_GAP + (int'(lfsrVal) % (1 << GAP_W));
`endif
  endfunction

  task automatic modelReset();
    mLfsr        = (SEED == 8'h00) ? 8'hA5 : SEED;
    mOut         = 1'b0;
    mLevel       = 1'b0;
    mBusy        = 1'b0;
    mDone        = 1'b0;
    mActive      = 1'b0;
    mNextToggle  = 0;
    mTogglesLeft = 0;
  endtask

  // Sequences are modelled as an absolute schedule of toggle edges.
  task automatic modelEdge(input logic inVal);
    mDone = 1'b0;
    if (mActive && edgeNum == mNextToggle && mTogglesLeft == 1) begin
      mOut    = ~mOut;
      mDone   = 1'b1;
      mBusy   = 1'b0;
      mActive = 1'b0;
    end else if (inVal != mLevel) begin
      mLevel       = inVal;
      mOut         = inVal;
      mBusy        = 1'b1;
      mActive      = 1'b1;
      mTogglesLeft = 2 * BOUNCE_CNT;
      mNextToggle  = edgeNum + gapOf(mLfsr);
    end else if (mActive && edgeNum == mNextToggle) begin
      mOut         = ~mOut;
      mTogglesLeft = mTogglesLeft - 1;
      mNextToggle  = edgeNum + gapOf(mLfsr);
    end
    mLfsr = lfsrNext(mLfsr);
  endtask

  task automatic applyStimulus(input logic inVal);
    in_clean = inVal;
    @(posedge clk);
    edgeNum++;
    modelEdge(inVal);
    @(negedge clk);
    checkOutput("out", out, mOut);
    checkOutput("busy", busy, mBusy);
    checkOutput("done", done, mDone);
    checkOutput("level", level, mLevel);
  endtask

  initial begin
    rst      = 1'b1;
    in_clean = 1'b0;
    cur      = 1'b0;
    hold     = 0;
    modelReset();
    repeat (3) @(negedge clk);
    checkOutput("rstOut", out, 1'b0);
    checkOutput("rstBusy", busy, 1'b0);
    checkOutput("rstDone", done, 1'b0);
    checkOutput("rstLevel", level, 1'b0);
    rst = 1'b0;

    // Rise, settle, fall, settle.
    repeat (5) applyStimulus(1'b0);
    cur = 1'b1;
    repeat (40) applyStimulus(cur);
    cur = 1'b0;
    repeat (40) applyStimulus(cur);

    // Abort partway through a sequence.
    cur = 1'b1;
    repeat (6) applyStimulus(cur);
    cur = 1'b0;
    repeat (40) applyStimulus(cur);

    // New level arriving on the very edge of the final toggle.
    for (int k = 0; k < 4; k++) begin
      cur = ~cur;
      applyStimulus(cur);
      found = 1'b0;
      for (int w = 0; w < 200 && !found; w++) begin
        if (mActive && mTogglesLeft == 1 && mNextToggle == edgeNum + 1) found = 1'b1;
        else applyStimulus(cur);
      end
      checkOutput("finalWait", found, 1'b1);
      cur = ~cur;
      applyStimulus(cur);
      repeat (50) applyStimulus(cur);
    end

    // Asynchronous reset in the middle of a sequence.
    cur = ~cur;
    repeat (4) applyStimulus(cur);
    #2 rst = 1'b1;
    #1;
    checkOutput("asyncOut", out, 1'b0);
    checkOutput("asyncBusy", busy, 1'b0);
    checkOutput("asyncDone", done, 1'b0);
    checkOutput("asyncLevel", level, 1'b0);
    modelReset();
    @(posedge clk);
    #2 rst = 1'b0;
    cur = 1'b0;
    repeat (10) applyStimulus(cur);

    // Random mix of short (aborting) and long (settling) holds.
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0) begin
        cur  = ~cur;
        hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 15)) : int'($urandom_range(20, 60));
      end
      hold--;
      applyStimulus(cur);
    end
    repeat (60) applyStimulus(cur);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
